// File: rtl/mem_lsu_seq_if.sv
// Data-bus side of the load/store sequencer: one beat per valid/ready handshake.
// master : the sequencer (drives the beat request, write data and byte enables)
// slave  : the memory or bridge (returns ready and read data)
// bus_valid  beat request
// bus_ready  beat accepted/completed
// bus_we     beat is a write
// bus_addr   beat address, aligned to BUS_BYTES
// bus_be     per-lane byte enable
// bus_wdata  lane-positioned write data
// bus_rdata  read data, valid when bus_valid && bus_ready
interface mem_lsu_seq_if #(
    parameter int BUS_BYTES = 2,
    parameter int ADDR_W    = 32
);
    logic                   bus_valid;
    logic                   bus_ready;
    logic                   bus_we;
    logic [ADDR_W-1:0]      bus_addr;
    logic [BUS_BYTES-1:0]   bus_be;
    logic [8*BUS_BYTES-1:0] bus_wdata;
    logic [8*BUS_BYTES-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_lsu_seq.sv
// Multi-beat load/store sequencer between the M-stage register and the data bus.
// Accepts one word/half/byte access, checks alignment, splits it into beats of
// BUS_BYTES bytes and returns sign/zero-extended load data.
// clk, reset (async, active low)
// start/kill/we/width/sign/addr/wdata : request from the pipeline
// busy, done, rdata, exc_adel, exc_ades : status back to the pipeline/stall logic
// bus : beat-level valid/ready bus (master side)
//
// state | meaning
// IDLE  | waiting for start
// XFER  | driving beats, one per bus_ready
// FIN   | one-cycle done pulse, load result presented
// ERR   | one-cycle address-error pulse
module mem_lsu_seq #(
    parameter int BUS_BYTES = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic              we,
    input  logic [1:0]        width,
    input  logic              sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              exc_adel,
    output logic              exc_ades,
    mem_lsu_seq_if.master     bus
);
    typedef enum logic [1:0] {IDLE, XFER, FIN, ERR} state_t;

    localparam logic [1:0] LAST_WORD = 2'(4 / BUS_BYTES - 1);
    localparam logic [1:0] LAST_HALF = 2'((BUS_BYTES >= 2) ? 0 : 1);
    localparam logic [2:0] BUS_SIZE  = 3'(BUS_BYTES);
    localparam logic [1:0] LANE_MASK = 2'(BUS_BYTES - 1);

    state_t state, state_nxt;

    logic              req_we;
    logic [1:0]        req_width;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        beat;
    logic [31:0]       buf_q;
    logic [31:0]       rdata_q;

    logic                   misaligned;
    logic                   accept;
    logic [2:0]             size;
    logic [1:0]             last_beat;
    logic                   sub_bus;
    logic [1:0]             off;
    logic [BUS_BYTES-1:0]   be_base;
    logic [8*BUS_BYTES-1:0] wsel;
    logic [8*BUS_BYTES-1:0] rd_shift;
    logic [31:0]            ext;

    assign misaligned = (width == 2'b11) ||
                        (width == 2'b01 && addr[0]) ||
                        (width == 2'b00 && addr[1:0] != 2'b00);
    assign accept = (state == IDLE) && start && !kill;

    always_comb begin
        size      = 3'd1;
        last_beat = 2'd0;
        be_base   = BUS_BYTES'(1);
        case (req_width)
            2'b00: begin
                size      = 3'd4;
                last_beat = LAST_WORD;
                be_base   = '1;
            end
            2'b01: begin
                size      = 3'd2;
                last_beat = LAST_HALF;
                be_base   = BUS_BYTES'(3);
            end
            default: ;
        endcase
    end

    // Narrow accesses occupy a single beat at lane offset addr mod BUS_BYTES.
    assign sub_bus  = size < BUS_SIZE;
    assign off      = sub_bus ? (req_addr[1:0] & LANE_MASK) : 2'd0;
    assign rd_shift = bus.bus_rdata >> {off, 3'b000};

    always_comb begin
        wsel = '0;
        for (int j = 0; j < 4; j++) begin
            if (j / BUS_BYTES == int'(beat)) begin
                wsel[8*(j % BUS_BYTES) +: 8] = req_wdata[8*j +: 8];
            end
        end
    end

    always_comb begin
        case (req_width)
            2'b00:   ext = buf_q;
            2'b01:   ext = {{16{req_sign & buf_q[15]}}, buf_q[15:0]};
            default: ext = {{24{req_sign & buf_q[7]}}, buf_q[7:0]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        done          = 1'b0;
        exc_adel      = 1'b0;
        exc_ades      = 1'b0;
        rdata         = rdata_q;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_be    = '0;
        bus.bus_wdata = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !kill) begin
                    state_nxt = misaligned ? ERR : XFER;
                end
            end
            XFER: begin
                bus.bus_valid = 1'b1;
                bus.bus_we    = req_we;
                bus.bus_addr  = (req_addr & ~ADDR_W'(BUS_BYTES - 1)) +
                                (ADDR_W'(beat) * ADDR_W'(BUS_BYTES));
                bus.bus_be    = sub_bus ? (be_base << off) : '1;
                bus.bus_wdata = wsel << {off, 3'b000};
                if (bus.bus_ready && beat == last_beat) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
                if (!req_we) begin
                    rdata = ext;
                end
            end
            ERR: begin
                exc_adel  = !req_we;
                exc_ades  = req_we;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_we    <= 1'b0;
            req_width <= 2'b00;
            req_sign  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            beat      <= 2'd0;
            buf_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                req_we    <= we;
                req_width <= width;
                req_sign  <= sign;
                req_addr  <= addr;
                req_wdata <= wdata;
                beat      <= 2'd0;
            end
            if (state == XFER && bus.bus_ready) begin
                beat <= beat + 2'd1;
                if (!req_we) begin
                    // Bytes above the access size may be filled with other lanes; ext ignores them.
                    for (int j = 0; j < 4; j++) begin
                        if (j / BUS_BYTES == int'(beat)) begin
                            buf_q[8*j +: 8] <= rd_shift[8*(j % BUS_BYTES) +: 8];
                        end
                    end
                end
            end
            if (state == FIN && !req_we) begin
                rdata_q <= ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu_seq.sv
module tb_mem_lsu_seq;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } beat_t;

    typedef struct {
        logic [2:0]  kind;   // {done, exc_adel, exc_ades}
        logic [31:0] rdata;
        int          issue_cyc;
        int          exp_lat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, kill, we, sign;
    logic [1:0]  width;
    logic [31:0] addr, wdata;

    logic [2:0]  busy_v, done_v, adel_v, ades_v, vld_v, rdy_v, bwe_v, bus_any_v;
    logic [31:0] rdata_v [3];
    logic [31:0] baddr_v [3];
    logic [3:0]  bbe_v   [3];
    logic [31:0] bwd_v   [3];

    beat_t exp_beats [3][$];
    res_t  exp_res   [3][$];

    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [31:0] last_rdata = 32'h0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ws_mode = 0;   // 0: always ready, 1: random wait states, 2: never ready

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string what);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", what);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int BB = 1 << g;
        mem_lsu_seq_if #(.BUS_BYTES(BB), .ADDR_W(32)) bif ();
        logic [7:0]      mem [256] = '{default: 8'h00};
        logic            rdy = 1'b0;
        logic [8*BB-1:0] rdd = '0;

        mem_lsu_seq #(.BUS_BYTES(BB), .ADDR_W(32)) dut (
            .clk(clk), .reset(reset), .start(start), .kill(kill), .we(we),
            .width(width), .sign(sign), .addr(addr), .wdata(wdata),
            .busy(busy_v[g]), .done(done_v[g]), .rdata(rdata_v[g]),
            .exc_adel(adel_v[g]), .exc_ades(ades_v[g]), .bus(bif)
        );

        assign bif.bus_ready = rdy;
        assign bif.bus_rdata = rdd;
        assign vld_v[g]      = bif.bus_valid;
        assign rdy_v[g]      = bif.bus_ready;
        assign bwe_v[g]      = bif.bus_we;
        assign baddr_v[g]    = bif.bus_addr;
        assign bbe_v[g]      = 4'(bif.bus_be);
        assign bwd_v[g]      = 32'(bif.bus_wdata);
        assign bus_any_v[g]  = bif.bus_valid | bif.bus_we | (|bif.bus_be) |
                               (|bif.bus_addr) | (|bif.bus_wdata);

        // Memory responder: writes land on the accepting edge, read data follows the new address.
        always @(posedge clk) begin
            if (bif.bus_valid && bif.bus_ready && bif.bus_we) begin
                for (int i = 0; i < BB; i++) begin
                    if (bif.bus_be[i]) mem[bif.bus_addr[7:0] + 8'(i)] = bif.bus_wdata[8*i +: 8];
                end
            end
            #1;
            case (ws_mode)
                0:       rdy = 1'b1;
                2:       rdy = 1'b0;
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            for (int i = 0; i < BB; i++) begin
                rdd[8*i +: 8] = mem[bif.bus_addr[7:0] + 8'(i)];
            end
        end
    end

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
        return m;
    endfunction

    // Scoreboard monitor: beats are compared against the queue head on every
    // valid cycle (so wait-state stability is covered) and popped on ready.
    always @(negedge clk) begin
        beat_t e;
        res_t  r;
        for (int i = 0; i < 3; i++) begin
            if (vld_v[i]) begin
                if (exp_beats[i].size() == 0) begin
                    check(1'b0, $sformatf("unexp_beat lane%0d addr=%h expected no beat", i, baddr_v[i]));
                end else begin
                    e = exp_beats[i][0];
                    check(baddr_v[i] == e.addr, $sformatf("beat_addr lane%0d got=%h exp=%h", i, baddr_v[i], e.addr));
                    check(bbe_v[i] == e.be, $sformatf("beat_be lane%0d got=%b exp=%b", i, bbe_v[i], e.be));
                    check(bwe_v[i] == e.we, $sformatf("beat_we lane%0d got=%b exp=%b", i, bwe_v[i], e.we));
                    if (e.we) begin
                        check(((bwd_v[i] ^ e.wdata) & byte_mask(e.be)) == 32'h0,
                              $sformatf("beat_wdata lane%0d got=%h exp=%h be=%b", i, bwd_v[i], e.wdata, e.be));
                    end
                    if (rdy_v[i]) void'(exp_beats[i].pop_front());
                end
            end
            if (done_v[i] | adel_v[i] | ades_v[i]) begin
                if (exp_res[i].size() == 0) begin
                    check(1'b0, $sformatf("unexp_result lane%0d got=%b expected none", i, {done_v[i], adel_v[i], ades_v[i]}));
                end else begin
                    r = exp_res[i].pop_front();
                    check({done_v[i], adel_v[i], ades_v[i]} == r.kind,
                          $sformatf("result_kind lane%0d got=%b exp=%b", i, {done_v[i], adel_v[i], ades_v[i]}, r.kind));
                    check(rdata_v[i] == r.rdata, $sformatf("rdata lane%0d got=%h exp=%h", i, rdata_v[i], r.rdata));
                    if (r.exp_lat >= 0) begin
                        check(cyc - r.issue_cyc == r.exp_lat,
                              $sformatf("latency lane%0d got=%0d exp=%0d", i, cyc - r.issue_cyc, r.exp_lat));
                    end
                end
            end
        end
    end

    // Reference model: expands one access into the beats each bus width must
    // show and the result it must return, and applies stores to ref_mem.
    task automatic push_req(input bit w, input logic [1:0] wd, input bit sg,
                            input logic [31:0] a, input logic [31:0] d, input bit lat_chk);
        int S, B, off;
        bit mis;
        logic [31:0] rd, v;
        beat_t bt;
        S   = (wd == 2'd0) ? 4 : (wd == 2'd1) ? 2 : 1;
        mis = (wd == 2'd3) || (wd == 2'd1 && a[0]) || (wd == 2'd0 && a[1:0] != 2'd0);
        rd  = last_rdata;
        if (!mis) begin
            if (w) begin
                for (int l = 0; l < S; l++) ref_mem[a[7:0] + 8'(l)] = d[8*l +: 8];
            end else begin
                v = 32'h0;
                for (int l = 0; l < S; l++) v[8*l +: 8] = ref_mem[a[7:0] + 8'(l)];
                if (sg && v[8*S-1]) v = v | ~((32'h1 << (8*S)) - 1);
                if (S == 4) v = {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2],
                                 ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
                rd = v;
                last_rdata = v;
            end
        end
        for (int i = 0; i < 3; i++) begin
            B = 1 << i;
            if (mis) begin
                exp_res[i].push_back('{kind: w ? 3'b001 : 3'b010, rdata: rd, issue_cyc: cyc, exp_lat: 1});
            end else begin
                if (S >= B) begin
                    for (int k = 0; k < S / B; k++) begin
                        bt.addr = (a & ~32'(B - 1)) + 32'(k * B);
                        bt.be = 4'((1 << B) - 1);
                        bt.we = w;
                        bt.wdata = 32'h0;
                        for (int l = 0; l < B; l++) bt.wdata[8*l +: 8] = d[8*(k*B + l) +: 8];
                        exp_beats[i].push_back(bt);
                    end
                end else begin
                    off = int'(a % 32'(B));
                    bt.addr = a & ~32'(B - 1);
                    bt.be = 4'(((1 << S) - 1) << off);
                    bt.we = w;
                    bt.wdata = 32'h0;
                    for (int l = 0; l < S; l++) bt.wdata[8*(off + l) +: 8] = d[8*l +: 8];
                    exp_beats[i].push_back(bt);
                end
                exp_res[i].push_back('{kind: 3'b100, rdata: rd, issue_cyc: cyc,
                                       exp_lat: lat_chk ? ((S >= B) ? S / B : 1) + 1 : -1});
            end
        end
    endtask

    task automatic issue(input bit w, input logic [1:0] wd, input bit sg, input logic [31:0] a,
                         input logic [31:0] d, input bit k, input bit lat_chk);
        @(posedge clk); #1;
        start = 1'b1; kill = k; we = w; width = wd; sign = sg; addr = a; wdata = d;
        if (!k) push_req(w, wd, sg, a, d, lat_chk);
        @(posedge clk); #1;
        // Scramble the request inputs after the accept edge; the latched copy must win.
        start = 1'b0; kill = 1'($urandom); we = 1'($urandom); width = 2'($urandom);
        sign = 1'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < 3; i++) if (exp_beats[i].size() != 0 || exp_res[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy_v == 3'b000 && queues_empty()) break;
        end
        check(n < 400, $sformatf("idle_timeout cycles=%0d limit=400", n));
    endtask

    task automatic check_rdata(input logic [31:0] exp, input string name);
        for (int i = 0; i < 3; i++) check(rdata_v[i] == exp, $sformatf("%s lane%0d got=%h exp=%h", name, i, rdata_v[i], exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc [3];
        start = 0; kill = 0; we = 0; width = 0; sign = 0; addr = 0; wdata = 0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check({busy_v[i], done_v[i], adel_v[i], ades_v[i]} == 4'b0,
                  $sformatf("reset_status lane%0d got=%b exp=0000", i, {busy_v[i], done_v[i], adel_v[i], ades_v[i]}));
            check(bus_any_v[i] == 1'b0, $sformatf("reset_bus lane%0d got=%b exp=0", i, bus_any_v[i]));
            check(rdata_v[i] == 32'h0, $sformatf("reset_rdata lane%0d got=%h exp=0", i, rdata_v[i]));
        end
        reset = 1'b1;
        wait_idle();

        // Store word, zero wait states; busy must last N+1 cycles.
        issue(1, 2'd0, 0, 32'h1000, 32'hAABBCCDD, 0, 1);
        bc = '{0, 0, 0};
        repeat (7) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (busy_v[i]) bc[i]++;
        end
        check(bc[0] == 5, $sformatf("busy_cycles lane0 got=%0d exp=5", bc[0]));
        check(bc[1] == 3, $sformatf("busy_cycles lane1 got=%0d exp=3", bc[1]));
        check(bc[2] == 2, $sformatf("busy_cycles lane2 got=%0d exp=2", bc[2]));
        wait_idle();

        issue(1, 2'd2, 0, 32'h1003, 32'h00000080, 0, 1); wait_idle();
        issue(0, 2'd2, 1, 32'h1003, 32'h0, 0, 1);        wait_idle();
        check_rdata(32'hFFFFFF80, "load_byte_signed");
        issue(0, 2'd2, 0, 32'h1003, 32'h0, 0, 1);        wait_idle();
        check_rdata(32'h00000080, "load_byte_zero");

        issue(1, 2'd0, 0, 32'h2000, 32'h44332211, 0, 1); wait_idle();
        ws_mode = 1;
        issue(0, 2'd0, 0, 32'h2000, 32'h0, 0, 0);        wait_idle();
        check_rdata(32'h44332211, "load_word_waits");
        ws_mode = 0;
        wait_idle();

        issue(0, 2'd1, 0, 32'h1001, 32'h0, 0, 1);        wait_idle();
        issue(1, 2'd0, 0, 32'h1002, 32'h0BADF00D, 0, 1); wait_idle();

        // Killed start: no activity at all.
        issue(1, 2'd0, 0, 32'h2000, 32'hDEADBEEF, 1, 0);
        repeat (4) begin
            @(negedge clk);
            check(busy_v == 3'b000, $sformatf("kill_busy got=%b exp=000", busy_v));
            check(vld_v == 3'b000, $sformatf("kill_valid got=%b exp=000", vld_v));
        end
        issue(0, 2'd0, 0, 32'h2000, 32'h0, 0, 1);        wait_idle();
        check_rdata(32'h44332211, "after_kill_load");

        // Start while busy is ignored.
        issue(1, 2'd0, 0, 32'h1010, 32'h12345678, 0, 1);
        start = 1'b1; kill = 1'b0; we = 1'b0; width = 2'd2; addr = 32'h1011;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        issue(0, 2'd0, 0, 32'h1010, 32'h0, 0, 1);        wait_idle();
        check_rdata(32'h12345678, "busy_start_ignored");

        ws_mode = 1;
        for (int t = 0; t < 80; t++) begin
            logic [1:0] wd;
            wd = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom), wd, 1'($urandom), 32'h1000 | 32'($urandom_range(0, 255)),
                  $urandom, ($urandom_range(0, 7) == 0), 0);
            wait_idle();
        end

        // Reset while a beat waits on ready.
        ws_mode = 2;
        @(negedge clk);
        issue(0, 2'd0, 0, 32'h1004, 32'h0, 0, 0);
        repeat (3) @(negedge clk);
        check(vld_v == 3'b111, $sformatf("wait_valid got=%b exp=111", vld_v));
        #2 reset = 1'b0;
        #1;
        check(vld_v == 3'b000, $sformatf("reset_drop_valid got=%b exp=000", vld_v));
        check(busy_v == 3'b000, $sformatf("reset_drop_busy got=%b exp=000", busy_v));
        check(bus_any_v == 3'b000, $sformatf("reset_drop_bus got=%b exp=000", bus_any_v));
        for (int i = 0; i < 3; i++) begin
            exp_beats[i].delete();
            exp_res[i].delete();
        end
        last_rdata = 32'h0;
        check_rdata(32'h0, "reset_drop_rdata");
        @(negedge clk);
        reset = 1'b1;
        ws_mode = 0;
        wait_idle();
        issue(0, 2'd0, 0, 32'h0, 32'h0, 0, 1);
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            check(exp_beats[i].size() == 0 && exp_res[i].size() == 0,
                  $sformatf("queues_drained lane%0d beats=%0d results=%0d exp=0", i, exp_beats[i].size(), exp_res[i].size()));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
